gpr_file_mp: RTL and testbench

// - Next-generation general-purpose register file for the pipelined core: parametrised width/depth,
//   NRD combinational read ports, two write ports (WB0 = older, WB1 = younger), same-cycle write bypass.
// - Adds asynchronous clear of all registers and a per-register busy scoreboard (set at issue,

---
 rtl/gpr_pkg.sv | 14 +
 rtl/gpr_scoreboard.sv | 41 ++++
 rtl/gpr_file_mp.sv | 75 +++++++
 tb/tb_gpr_file_mp.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared sizing, types and constants for the general-purpose register file.
package gpr_pkg;

    localparam int GPR_DW  = 32;
    localparam int GPR_AW  = 5;
    localparam int GPR_NRD = 2;
    localparam int DEPTH   = 1 << GPR_AW;

    typedef logic [GPR_AW-1:0] reg_addr_t;
    typedef logic [GPR_DW-1:0] reg_data_t;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy tracking: set when a producer issues, cleared when its result is written back.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int AW = GPR_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_sel,
    input  logic                 we0,
    input  logic [AW-1:0]        we_sel0,
    input  logic                 we1,
    input  logic [AW-1:0]        we_sel1,
    output logic [(1<<AW)-1:0]   busy,
    output logic                 any_busy
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] busy_q;

    // Issue beats writeback on the same register: the new producer supersedes the old result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q[ZERO_REG] <= 1'b0;
            for (int r = 1; r < NREG; r++) begin
                if (issue_en && issue_sel == AW'(r))
                    busy_q[r] <= 1'b1;
                else if ((we0 && we_sel0 == AW'(r)) || (we1 && we_sel1 == AW'(r)))
                    busy_q[r] <= 1'b0;
            end
        end
    end

    assign busy     = busy_q;
    assign any_busy = |busy_q;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port register file with two writeback ports, same-cycle bypass and a busy scoreboard.
module gpr_file_mp
    import gpr_pkg::*;
#(
    parameter int DW  = GPR_DW,
    parameter int AW  = GPR_AW,
    parameter int NRD = GPR_NRD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] ReSel,
    output logic [NRD*DW-1:0] DataOut,
    output logic [NRD-1:0]    RdBusy,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [AW-1:0]     WeSel0,
    input  logic [AW-1:0]     WeSel1,
    input  logic [DW-1:0]     WData0,
    input  logic [DW-1:0]     WData1,
    input  logic              IssueEn,
    input  logic [AW-1:0]     IssueSel,
    output logic              AnyBusy
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0]   gpr_q [NREG];
    logic [NREG-1:0] busy;

    // WB1 is applied last so the younger result wins a same-register collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) gpr_q[r] <= '0;
        end else begin
            if (WE0 && WeSel0 != AW'(ZERO_REG)) gpr_q[WeSel0] <= WData0;
            if (WE1 && WeSel1 != AW'(ZERO_REG)) gpr_q[WeSel1] <= WData1;
        end
    end

    gpr_scoreboard #(.AW(AW)) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue_en  (IssueEn),
        .issue_sel (IssueSel),
        .we0       (WE0),
        .we_sel0   (WeSel0),
        .we1       (WE1),
        .we_sel1   (WeSel1),
        .busy      (busy),
        .any_busy  (AnyBusy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] sel;
        logic          hit0;
        logic          hit1;
        logic [DW-1:0] rd_data;

        assign sel  = ReSel[i*AW +: AW];
        assign hit0 = WE0 && (sel == WeSel0);
        assign hit1 = WE1 && (sel == WeSel1);

        // Outputs are forced quiet while reset is held, even if a write is being driven.
        always_comb begin
            if (!rst_n || sel == AW'(ZERO_REG)) rd_data = '0;
            else if (hit1)                     rd_data = WData1;
            else if (hit0)                     rd_data = WData0;
            else                               rd_data = gpr_q[sel];
        end

        assign DataOut[i*DW +: DW] = rd_data;
        assign RdBusy[i]           = rst_n && busy[sel] && !(hit0 || hit1);
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Scoreboard-driven bench for gpr_file_mp: directed scenarios followed by a modelled random run.
module tb_gpr_file_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_ANY  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRD*AW-1:0] ReSel;
    logic [NRD*DW-1:0] DataOut;
    logic [NRD-1:0]    RdBusy;
    logic              WE0, WE1;
    logic [AW-1:0]     WeSel0, WeSel1;
    logic [DW-1:0]     WData0, WData1;
    logic              IssueEn;
    logic [AW-1:0]     IssueSel;
    logic              AnyBusy;

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [DW-1:0] m_gpr [32];
    logic          m_busy [32];

    gpr_file_mp #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ReSel    (ReSel),
        .DataOut  (DataOut),
        .RdBusy   (RdBusy),
        .WE0      (WE0),
        .WE1      (WE1),
        .WeSel0   (WeSel0),
        .WeSel1   (WeSel1),
        .WData0   (WData0),
        .WData1   (WData1),
        .IssueEn  (IssueEn),
        .IssueSel (IssueSel),
        .AnyBusy  (AnyBusy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic expect_out(input string tag, input int kind, input int port, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.kind = kind; e.port = port; e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic check_outputs();
        exp_t        e;
        logic [31:0] got;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
                K_DATA:  got = DataOut[e.port*DW +: DW];
                K_BUSY:  got = {31'b0, RdBusy[e.port]};
                default: got = {31'b0, AnyBusy};
            endcase
            chk(e.tag, got, e.exp);
        end
    endtask

    task automatic idle_inputs();
        WE0 = 1'b0; WE1 = 1'b0; IssueEn = 1'b0;
        WeSel0 = '0; WeSel1 = '0; WData0 = '0; WData1 = '0; IssueSel = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ReSel = {a1, a0};
    endtask

    // Check mid-cycle, advance past the next rising edge, return inputs to idle.
    task automatic cyc();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] sel);
        if (sel == 0)                    return '0;
        else if (WE1 && sel == WeSel1)   return WData1;
        else if (WE0 && sel == WeSel0)   return WData0;
        else                             return m_gpr[sel];
    endfunction

    function automatic logic m_rdbusy(input logic [AW-1:0] sel);
        return m_busy[sel] && !((WE0 && sel == WeSel0) || (WE1 && sel == WeSel1));
    endfunction

    function automatic logic m_any();
        logic a = 1'b0;
        for (int r = 0; r < 32; r++) a |= m_busy[r];
        return a;
    endfunction

    initial begin
        logic [AW-1:0] s0, s1;
        rst_n = 1'b0;
        idle_inputs();
        set_rd(5'd5, 5'd0);
        #2;
        expect_out("rst_dout0", K_DATA, 0, 32'h0);
        expect_out("rst_dout1", K_DATA, 1, 32'h0);
        expect_out("rst_rdbusy0", K_BUSY, 0, 32'h0);
        expect_out("rst_anybusy", K_ANY, 0, 32'h0);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // write r5, issue r6, then reset mid-cycle with a write in flight
        set_rd(5'd5, 5'd6);
        WE0 = 1'b1; WeSel0 = 5'd5; WData0 = 32'hDEADBEEF;
        IssueEn = 1'b1; IssueSel = 5'd6;
        expect_out("wr5_bypass", K_DATA, 0, 32'hDEADBEEF);
        expect_out("iss6_same_cycle_rdbusy", K_BUSY, 1, 32'h0);
        expect_out("iss6_same_cycle_any", K_ANY, 0, 32'h0);
        cyc();
        expect_out("r5_stored", K_DATA, 0, 32'hDEADBEEF);
        expect_out("r6_busy", K_BUSY, 1, 32'h1);
        expect_out("any_after_iss6", K_ANY, 0, 32'h1);
        check_outputs();
        WE0 = 1'b1; WeSel0 = 5'd5; WData0 = 32'h00000123;
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst_dout0", K_DATA, 0, 32'h0);
        expect_out("async_rst_rdbusy1", K_BUSY, 1, 32'h0);
        expect_out("async_rst_any", K_ANY, 0, 32'h0);
        check_outputs();
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        #1;
        expect_out("rst_write_discarded", K_DATA, 0, 32'h0);
        expect_out("rst_busy6_cleared", K_BUSY, 1, 32'h0);
        expect_out("rst_any_cleared", K_ANY, 0, 32'h0);
        check_outputs();
        @(posedge clk);
        #1;

        // bypass
        set_rd(5'd3, 5'd0);
        WE0 = 1'b1; WeSel0 = 5'd3; WData0 = 32'h11;
        expect_out("bypass_r3", K_DATA, 0, 32'h11);
        cyc();
        expect_out("stored_r3", K_DATA, 0, 32'h11);
        expect_out("nonbusy_write_any", K_ANY, 0, 32'h0);
        cyc();

        // collision on r7
        set_rd(5'd7, 5'd7);
        WE0 = 1'b1; WeSel0 = 5'd7; WData0 = 32'hAAAA;
        WE1 = 1'b1; WeSel1 = 5'd7; WData1 = 32'h5555;
        expect_out("coll_bypass0", K_DATA, 0, 32'h5555);
        expect_out("coll_bypass1", K_DATA, 1, 32'h5555);
        cyc();
        expect_out("coll_stored", K_DATA, 0, 32'h5555);
        cyc();

        // register zero
        set_rd(5'd0, 5'd7);
        WE1 = 1'b1; WeSel1 = 5'd0; WData1 = 32'hFFFFFFFF;
        IssueEn = 1'b1; IssueSel = 5'd0;
        expect_out("r0_bypass", K_DATA, 0, 32'h0);
        expect_out("r0_rdbusy", K_BUSY, 0, 32'h0);
        cyc();
        expect_out("r0_after", K_DATA, 0, 32'h0);
        expect_out("r0_rdbusy_after", K_BUSY, 0, 32'h0);
        expect_out("r0_any_after", K_ANY, 0, 32'h0);
        cyc();

        // scoreboard r9
        set_rd(5'd9, 5'd3);
        IssueEn = 1'b1; IssueSel = 5'd9;
        expect_out("iss9_same_cycle", K_BUSY, 0, 32'h0);
        cyc();
        expect_out("r9_busy", K_BUSY, 0, 32'h1);
        expect_out("r9_any", K_ANY, 0, 32'h1);
        expect_out("r9_other_port", K_BUSY, 1, 32'h0);
        cyc();
        WE0 = 1'b1; WeSel0 = 5'd9; WData0 = 32'h42;
        expect_out("wb9_forward_busy", K_BUSY, 0, 32'h0);
        expect_out("wb9_forward_data", K_DATA, 0, 32'h42);
        expect_out("wb9_any_no_lookahead", K_ANY, 0, 32'h1);
        cyc();
        expect_out("r9_cleared", K_BUSY, 0, 32'h0);
        expect_out("r9_any_cleared", K_ANY, 0, 32'h0);
        expect_out("r9_stored", K_DATA, 0, 32'h42);
        cyc();

        // issue and writeback to r4 in the same cycle
        set_rd(5'd4, 5'd9);
        IssueEn = 1'b1; IssueSel = 5'd4;
        cyc();
        IssueEn = 1'b1; IssueSel = 5'd4;
        WE1 = 1'b1; WeSel1 = 5'd4; WData1 = 32'h77;
        expect_out("iss_wb4_fwd_busy", K_BUSY, 0, 32'h0);
        expect_out("iss_wb4_fwd_data", K_DATA, 0, 32'h77);
        cyc();
        expect_out("iss_wb4_set_wins", K_BUSY, 0, 32'h1);
        expect_out("iss_wb4_stored", K_DATA, 0, 32'h77);
        expect_out("iss_wb4_any", K_ANY, 0, 32'h1);
        cyc();
        WE0 = 1'b1; WeSel0 = 5'd4; WData0 = 32'h88;
        cyc();
        expect_out("r4_drained", K_ANY, 0, 32'h0);
        cyc();

        // distinct addresses on both write ports
        set_rd(5'd10, 5'd11);
        WE0 = 1'b1; WeSel0 = 5'd10; WData0 = 32'hA0;
        WE1 = 1'b1; WeSel1 = 5'd11; WData1 = 32'hB0;
        expect_out("dual_wr_p0", K_DATA, 0, 32'hA0);
        expect_out("dual_wr_p1", K_DATA, 1, 32'hB0);
        cyc();

        // random run against a behavioural model
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            m_gpr[r] = '0;
            m_busy[r] = 1'b0;
        end
        for (int n = 0; n < 200; n++) begin
            s0 = 5'($urandom_range(0, 7));
            s1 = 5'($urandom_range(0, 7));
            set_rd(s0, s1);
            WE0 = 1'($urandom); WeSel0 = 5'($urandom_range(0, 7)); WData0 = $urandom;
            WE1 = 1'($urandom); WeSel1 = 5'($urandom_range(0, 7)); WData1 = $urandom;
            IssueEn = 1'($urandom); IssueSel = 5'($urandom_range(0, 7));
            expect_out("rnd_dout0", K_DATA, 0, m_read(s0));
            expect_out("rnd_dout1", K_DATA, 1, m_read(s1));
            expect_out("rnd_rdbusy0", K_BUSY, 0, {31'b0, m_rdbusy(s0)});
            expect_out("rnd_rdbusy1", K_BUSY, 1, {31'b0, m_rdbusy(s1)});
            expect_out("rnd_any", K_ANY, 0, {31'b0, m_any()});
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            for (int r = 1; r < 32; r++) begin
                if (IssueEn && IssueSel == 5'(r))
                    m_busy[r] = 1'b1;
                else if ((WE0 && WeSel0 == 5'(r)) || (WE1 && WeSel1 == 5'(r)))
                    m_busy[r] = 1'b0;
            end
            if (WE0 && WeSel0 != 0) m_gpr[WeSel0] = WData0;
            if (WE1 && WeSel1 != 0) m_gpr[WeSel1] = WData1;
            #1;
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
